// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the single-port memory arbiter.
//   arb_state_t : arbiter FSM states (ARB_IDLE / ARB_REQ / ARB_RESP)
//   arb_owner_t : owner of the current bus transaction (OWN_IF / OWN_DM)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: requester selection for the arbiter's IDLE acceptance.
// Data wins over fetch. With MEM_ARB_FAIR_EN defined, a counter tracks data
// grants taken while fetch waits; at FAIR_MAX with both pending, fetch wins.
// Ports:
//   clk_i, rst, take_i : clock, async active-low reset, acceptance strobe
//                        (present only with MEM_ARB_FAIR_EN)
//   if_req_i, dm_req_i : pending fetch / data requests
//   owner_o            : owner for an acceptance in this cycle
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned FAIR_MAX = 4
) (
`ifdef MEM_ARB_FAIR_EN
  input  logic       clk_i,
  input  logic       rst,
  input  logic       take_i,
`endif
  input  logic       if_req_i,
  input  logic       dm_req_i,
  output arb_owner_t owner_o
);

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(FAIR_MAX + 1);

  logic [CNT_W-1:0] fair_cnt;
  logic             fetch_turn;

  assign fetch_turn = if_req_i && dm_req_i && (fair_cnt == CNT_W'(FAIR_MAX));

  always_comb begin
    owner_o = OWN_DM;
    if (fetch_turn || (if_req_i && !dm_req_i)) owner_o = OWN_IF;
  end

  // Never exceeds FAIR_MAX: at the limit the next acceptance goes to fetch.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      fair_cnt <= '0;
    end else if (!if_req_i) begin
      fair_cnt <= '0;
    end else if (take_i) begin
      if (owner_o == OWN_IF) fair_cnt <= '0;
      else                   fair_cnt <= fair_cnt + 1'b1;
    end
  end
`else
  always_comb begin
    owner_o = OWN_DM;
    if (if_req_i && !dm_req_i) owner_o = OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between fetch and memory stage.
// Registered IDLE -> REQ -> RESP FSM, responses routed to the owner, fetches
// cancelled on flush_i, combinational stall requests for the hazard unit.
// Fetch transactions are issued as full-word reads (be all ones, wdata 0).
// Optional feature: MEM_ARB_FAIR_EN enables the fetch fairness counter.
// Ports:
//   clk_i, rst                  : clock, async active-low reset
//   if_req_i/if_addr_i          : fetch request in; if_rvalid_o/if_rdata_o out
//   dm_req_i/we/be/addr/wdata   : data request in; dm_rvalid_o/dm_rdata_o out
//   flush_i                     : branch redirect, cancels the current fetch
//   if_stall_o, dm_stall_o      : stall requests
//   bus_req/we/be/addr/wdata_o  : registered bus request
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i : bus handshake and read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned FAIR_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  input  logic                flush_i,
  output logic                if_stall_o,
  output logic                dm_stall_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, pick_owner;
  logic       drop_q, drop_d;
  logic       accept, if_flush, resp;

  assign accept   = (state_q == ARB_IDLE) && (if_req_i || dm_req_i);
  assign if_flush = flush_i && (owner_q == OWN_IF);
  assign resp     = (state_q == ARB_RESP) && bus_rvalid_i;

  mem_arb_pick #(
    .FAIR_MAX (FAIR_MAX)
  ) u_pick (
`ifdef MEM_ARB_FAIR_EN
    .clk_i    (clk_i),
    .rst      (rst),
    .take_i   (accept),
`endif
    .if_req_i (if_req_i),
    .dm_req_i (dm_req_i),
    .owner_o  (pick_owner)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_REQ;
      ARB_REQ: begin
        if (bus_gnt_i) begin
          state_d = ARB_RESP;
          if (if_flush) drop_d = 1'b1;
        end else if (if_flush) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_RESP: begin
        if (if_flush) drop_d = 1'b1;
        if (bus_rvalid_i) begin
          state_d = ARB_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      drop_q    <= 1'b0;
      bus_req_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      bus_req_o <= (state_d == ARB_REQ);
    end
  end

  // Request latch: bus fields hold from REQ entry until the next acceptance.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_IF;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else if (accept) begin
      owner_q <= pick_owner;
      if (pick_owner == OWN_DM) begin
        bus_we_o    <= dm_we_i;
        bus_be_o    <= dm_be_i;
        bus_addr_o  <= dm_addr_i;
        bus_wdata_o <= dm_wdata_i;
      end else begin
        bus_we_o    <= 1'b0;
        bus_be_o    <= '1;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
      end
    end
  end

  // A flush in the response cycle itself drops the fetch data too.
  assign if_rvalid_o = resp && (owner_q == OWN_IF) && !drop_q && !flush_i;
  assign dm_rvalid_o = resp && (owner_q == OWN_DM);
  assign if_rdata_o  = bus_rdata_i;
  assign dm_rdata_o  = bus_rdata_i;

  // Gated by reset so both stall requests read 0 while reset is held.
  assign if_stall_o = rst && if_req_i && !if_rvalid_o;
  assign dm_stall_o = rst && dm_req_i && !dm_rvalid_o;

endmodule
